// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int unsigned V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  localparam int unsigned COORD_W      = 10;
  localparam int unsigned FCOUNT_W     = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_bundle_t;

  // Inactive sync levels, used as the delay-line reset contents
  localparam sync_bundle_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the renderer / connector.
// Optional frame_count member present when VGA_FRAME_COUNTER_EN is defined.
interface vga_timing_gen_if;

  vga_timing_pkg::coord_t DrawX;
  vga_timing_pkg::coord_t DrawY;
  logic                   blank;
  logic                   blank_d;
  logic                   hs;
  logic                   vs;
  logic                   frame_start;
`ifdef VGA_FRAME_COUNTER_EN
  logic [vga_timing_pkg::FCOUNT_W-1:0] frame_count;

  modport master (output DrawX, DrawY, blank, blank_d, hs, vs, frame_start, frame_count);
  modport slave  (input  DrawX, DrawY, blank, blank_d, hs, vs, frame_start, frame_count);
`else
  modport master (output DrawX, DrawY, blank, blank_d, hs, vs, frame_start);
  modport slave  (input  DrawX, DrawY, blank, blank_d, hs, vs, frame_start);
`endif

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with async active-low reset to RST_VAL.
// DEPTH = 0 degenerates to a wire.
module sync_delay_line #(
  parameter int unsigned             DEPTH   = 2,
  parameter int unsigned             WIDTH   = 3,
  parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    // New sample enters stage 0; the oldest stage falls off the top
    always_comb begin
      stage_d = (DEPTH*WIDTH)'({stage_q, din});
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stage_q <= {DEPTH{RST_VAL}};
      else        stage_q <= stage_d;
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, visible-area flag and pipelined sync outputs.
// Define VGA_FRAME_COUNTER_EN to add the 16-bit frame_count output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HT > 1024 || VT > 1024 || SYNC_DELAY > 4) begin : g_param_err
    $error("vga_timing_gen: totals must fit 10-bit coordinates and SYNC_DELAY must be 0..4");
  end

  localparam coord_t X_LAST = coord_t'(HT - 1);
  localparam coord_t Y_LAST = coord_t'(VT - 1);
  localparam coord_t X_VIS  = coord_t'(H_ACTIVE);
  localparam coord_t Y_VIS  = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_LO  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t       x_q, x_d, y_q, y_d;
  logic         vis_q, vis_d;
  logic         fstart_q, fstart_d;
  sync_bundle_t raw, dly;

  // Raster advance; blank and frame_start decode the next position so they
  // line up with DrawX/DrawY without skew
  always_comb begin
    x_d      = x_q + 10'd1;
    y_d      = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
    end
    vis_d    = (x_d < X_VIS) && (y_d < Y_VIS);
    fstart_d = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      vis_q    <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      vis_q    <= vis_d;
      fstart_q <= fstart_d;
    end
  end

  // Undelayed sync/blank levels for the current raster position
  always_comb begin
    raw       = SYNC_IDLE;
    raw.hs    = !in_span(x_q, HS_LO, HS_HI);
    raw.vs    = !in_span(y_q, VS_LO, VS_HI);
    raw.blank = (x_q < X_VIS) && (y_q < Y_VIS);
  end

  sync_delay_line #(
    .DEPTH   (SYNC_DELAY),
    .WIDTH   ($bits(sync_bundle_t)),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .din   (raw),
    .dout  (dly)
  );

  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.blank       = vis_q;
  assign vga.blank_d     = dly.blank;
  assign vga.hs          = dly.hs;
  assign vga.vs          = dly.vs;
  assign vga.frame_start = fstart_q;

`ifdef VGA_FRAME_COUNTER_EN
  logic [FCOUNT_W-1:0] fcnt_q, fcnt_d;

  // Counts completed frames, wrapping naturally at 16 bits
  always_comb begin
    fcnt_d = fcnt_q;
    if (fstart_q) fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end

  assign vga.frame_count = fcnt_q;
`endif

endmodule
